rom_arbiter: RTL

Two-requester arbiter that shares one synchronous single-port ROM (registered read, one-cycle read latency) between an instruction-fetch port (port 0) and a data-load port (port 1). It sits between the CPU's fetch/load units and the ROM instance. It accepts at most one request per cycle, drives the ROM address, tracks the in-flight read, and returns the registered data to the owning port as a one-cycle response pulse.

---
 rtl/rom_arb_pkg.sv | 16 +
 rtl/rom_arb_pick.sv | 20 ++
 rtl/rom_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_LOAD  = 1;

    typedef logic owner_t;

    // One pipeline stage: a read in flight and the port that owns it.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } stage_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Two-way grant picker: a lone valid wins, otherwise the pointer selects the port.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
    input  logic                 ptr,
    output logic [NUM_PORTS-1:0] grant_c
);

    always_comb begin
        grant_c = '0;
        if (valid[PORT_FETCH] && valid[PORT_LOAD]) begin
            grant_c[PORT_FETCH] = ~ptr;
            grant_c[PORT_LOAD]  = ptr;
        end else begin
            grant_c = valid;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-output ROM between fetch (port 0) and load (port 1).
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed port-0 priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    logic [NUM_PORTS-1:0] valid;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [NUM_PORTS-1:0] grant;
    logic                 rr_ptr;
    stage_t               s1;

    assign valid = {req1_valid, req0_valid};

    rom_arb_pick u_pick (
        .valid   (valid),
        .ptr     (rr_ptr),
        .grant_c (pick_grant)
    );

    // No grant can be issued while reset is held.
    assign grant      = pick_grant & {NUM_PORTS{resetn}};
    assign req0_ready = grant[PORT_FETCH];
    assign req1_ready = grant[PORT_LOAD];

`ifdef ROM_ARB_RR_EN
    // Flip toward the loser only when both ports competed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 1'b0;
        end else if (&valid) begin
            rr_ptr <= grant[PORT_FETCH];
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

    always_comb begin
        rom_addr = '0;
        if (grant[PORT_FETCH]) begin
            rom_addr = req0_addr;
        end else if (grant[PORT_LOAD]) begin
            rom_addr = req1_addr;
        end
    end

    // Stage 1: ROM read in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= '0;
        end else begin
            s1.valid <= |grant;
            s1.owner <= owner_t'(grant[PORT_LOAD]);
        end
    end

    // Stage 2: capture rom_q into the owner's response register only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= s1.valid && (s1.owner == owner_t'(PORT_FETCH));
            rsp1_valid <= s1.valid && (s1.owner == owner_t'(PORT_LOAD));
            if (s1.valid && (s1.owner == owner_t'(PORT_FETCH))) begin
                rsp0_data <= rom_q;
            end
            if (s1.valid && (s1.owner == owner_t'(PORT_LOAD))) begin
                rsp1_data <= rom_q;
            end
        end
    end

endmodule
